// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between MEM and host.
// Core has priority; the host gets a starvation guard and bounded locks.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 4,
  parameter int MAX_LOCK   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_stall_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              host_lock_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_ARB,
    S_LOCK,
    S_YIELD
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_e;

  state_e            state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [DATA_W-1:0] core_rdata_q;
  logic              core_gnt;
  logic              host_gnt;
  logic              host_force;

  assign host_force = wait_cnt_q >= 4'(STARVE_LIM);

  // Grants are held low while in reset so every output reads 0.
  always_comb begin
    core_gnt   = 1'b0;
    host_gnt   = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (rst_ni) begin
      unique case (state_q)
        S_ARB: begin
          core_gnt = core_req_i & ~(host_req_i & host_force);
          host_gnt = ~core_gnt & host_req_i;
          if (host_gnt && host_lock_i) begin
            state_d    = S_LOCK;
            lock_cnt_d = 8'd1;
          end
        end
        S_LOCK: begin
          host_gnt   = host_req_i;
          lock_cnt_d = lock_cnt_q + 8'd1;
          if (!host_lock_i) begin
            state_d = S_ARB;
          end else if (lock_cnt_q == 8'(MAX_LOCK)) begin
            state_d = S_YIELD;
          end
        end
        S_YIELD: begin
          core_gnt = core_req_i;
          host_gnt = host_req_i & ~core_req_i;
          state_d  = S_ARB;
        end
        default: state_d = S_ARB;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = 4'd0;
    if (host_req_i && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == 4'hf) ? wait_cnt_q
                                        : wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (core_gnt && !core_we_i) begin
      rd_owner_d = OWN_CORE;
    end else if (host_gnt && !host_we_i) begin
      rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_ARB;
      rd_owner_q   <= OWN_NONE;
      wait_cnt_q   <= 4'd0;
      lock_cnt_q   <= 8'd0;
      core_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      if (rd_owner_q == OWN_CORE) begin
        core_rdata_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_gnt) begin
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (host_gnt) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
    end
  end

  assign mem_we_o = (core_gnt & core_we_i)
                  | (host_gnt & host_we_i);
  assign mem_re_o = (core_gnt & ~core_we_i)
                  | (host_gnt & ~host_we_i);

  assign core_stall_o  = rst_ni & core_req_i & ~core_gnt;
  assign host_gnt_o    = host_gnt;
  assign host_rvalid_o = rd_owner_q == OWN_HOST;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
  assign core_rdata_o  = (rd_owner_q == OWN_CORE) ? mem_rdata_i
                                                  : core_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random + directed stimulus, reference model and scoreboard.
// Expected outputs are queued per cycle and checked by a negedge monitor.
module tb_dmem_arbiter;

  localparam int SL = 4;
  localparam int ML = 16;

  logic        clk;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [7:0]  core_addr_i;
  logic [63:0] core_wdata_i;
  logic        core_stall_o;
  logic [63:0] core_rdata_o;
  logic        host_req_i, host_we_i, host_lock_i;
  logic [7:0]  host_addr_i;
  logic [63:0] host_wdata_i;
  logic        host_gnt_o, host_rvalid_o;
  logic [63:0] host_rdata_o;
  logic        mem_re_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;

  dmem_arbiter #(
    .ADDR_W(8), .DATA_W(64), .STARVE_LIM(SL), .MAX_LOCK(ML)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_stall_o(core_stall_o), .core_rdata_o(core_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_lock_i(host_lock_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 64'h0123456789ABCDEF;
    return {24'hC0DE00, a, ~{24'd0, a} * 32'd2654435761};
  endfunction

  // Memory environment: fresh data after a read, garbage otherwise.
  logic [63:0] env_mem [256];
  bit          env_wr  [256];
  always @(posedge clk) begin
    if (mem_we_o) begin
      env_mem[mem_addr_o] <= mem_wdata_o;
      env_wr[mem_addr_o]  <= 1'b1;
    end
    if (mem_re_o) begin
      mem_rdata_i <= env_wr[mem_addr_o] ? env_mem[mem_addr_o]
                                        : init_val(mem_addr_o);
    end else begin
      mem_rdata_i <= {$urandom, $urandom};
    end
  end

  typedef struct {
    bit rst, cr, cw, hr, hw, hl;
    logic [7:0] ca, ha;
    logic [63:0] cd, hd;
  } stim_t;

  typedef struct {
    logic stall, hgnt, re, we, hrv;
    logic [7:0] addr;
    logic [63:0] wdata, crdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] host_q[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  logic [63:0] ref_mem [256];
  bit          in_lock, in_yield, pend_core, pend_host;
  int          lock_cycles, waited;
  logic [63:0] pend_core_val, core_hold;

  task automatic model_reset();
    in_lock = 0; in_yield = 0; lock_cycles = 0; waited = 0;
    pend_core = 0; pend_host = 0; core_hold = '0;
    host_q.delete();
  endtask

  task automatic cyc(input stim_t s);
    exp_t e;
    bit cg, hg;
    @(posedge clk);
    #1;
    rst_ni = s.rst;
    core_req_i = s.cr; core_we_i = s.cw;
    core_addr_i = s.ca; core_wdata_i = s.cd;
    host_req_i = s.hr; host_we_i = s.hw; host_lock_i = s.hl;
    host_addr_i = s.ha; host_wdata_i = s.hd;
    e = '{default: 0};
    if (!s.rst) begin
      model_reset();
    end else begin
      if (pend_core) core_hold = pend_core_val;
      e.crdata = core_hold;
      e.hrv = pend_host;
      if (in_lock) begin
        cg = 0; hg = s.hr;
      end else if (in_yield) begin
        cg = s.cr; hg = s.hr && !s.cr;
      end else begin
        cg = s.cr && !(s.hr && waited >= SL);
        hg = s.hr && !cg;
      end
      e.stall = s.cr && !cg;
      e.hgnt = hg;
      if (cg) begin
        e.we = s.cw; e.re = !s.cw; e.addr = s.ca; e.wdata = s.cd;
      end else if (hg) begin
        e.we = s.hw; e.re = !s.hw; e.addr = s.ha; e.wdata = s.hd;
      end
      pend_core = cg && !s.cw;
      pend_core_val = ref_mem[s.ca];
      pend_host = hg && !s.hw;
      if (pend_host) host_q.push_back(ref_mem[s.ha]);
      if (e.we) ref_mem[e.addr] = e.wdata;
      waited = (s.hr && !hg) ? ((waited < 15) ? waited + 1 : 15) : 0;
      if (in_lock) begin
        if (!s.hl) in_lock = 0;
        else if (lock_cycles == ML) begin
          in_lock = 0; in_yield = 1;
        end
        lock_cycles++;
      end else if (in_yield) begin
        in_yield = 0;
      end else if (hg && s.hl) begin
        in_lock = 1; lock_cycles = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", n, $time, a, x);
    end
  endtask

  exp_t m;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("core_stall", core_stall_o, m.stall);
      chk("host_gnt", host_gnt_o, m.hgnt);
      chk("mem_re", mem_re_o, m.re);
      chk("mem_we", mem_we_o, m.we);
      chk("mem_addr", mem_addr_o, m.addr);
      chk("mem_wdata", mem_wdata_o, m.wdata);
      chk("core_rdata", core_rdata_o, m.crdata);
      chk("host_rvalid", host_rvalid_o, m.hrv);
      if (!host_rvalid_o) chk("host_rdata_idle", host_rdata_o, 64'd0);
    end
    if (host_rvalid_o) begin
      if (host_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL host_rvalid_unexpected t=%0t actual=1 required=0",
                 $time);
      end else begin
        chk("host_rdata", host_rdata_o, host_q.pop_front());
      end
    end
  end

  stim_t s;
  int pc, ph, pl, pw, ar;

  function automatic bit rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    model_reset();
    rst_ni = 0; core_req_i = 0; core_we_i = 0; core_addr_i = 0;
    core_wdata_i = 0; host_req_i = 0; host_we_i = 0; host_lock_i = 0;
    host_addr_i = 0; host_wdata_i = 0;
    s = '{default: 0};
    repeat (3) cyc(s);
    s.rst = 1;
    cyc(s);
    // core read of the preloaded word
    s.cr = 1; s.ca = 8'h10; cyc(s);
    s = '{default: 0}; s.rst = 1; cyc(s);
    // host write then read-back
    s.hr = 1; s.hw = 1; s.ha = 8'h3; s.hd = 64'hA5; cyc(s);
    s.hw = 0; s.hd = 0; cyc(s);
    s = '{default: 0}; s.rst = 1; cyc(s);
    // continuous contention: host forced in every SL+1 cycles
    for (int i = 0; i < 20; i++) begin
      s.cr = 1; s.hr = 1; s.cw = rnd(50); s.hw = rnd(50);
      s.ca = 8'($urandom_range(15)); s.ha = 8'($urandom_range(15));
      s.cd = {$urandom, $urandom}; s.hd = {$urandom, $urandom};
      cyc(s);
    end
    // long lock, core requesting throughout
    s = '{default: 0}; s.rst = 1; cyc(s);
    s.hr = 1; s.hl = 1; s.ha = 8'h5; cyc(s);
    for (int i = 0; i < 22; i++) begin
      s.cr = 1; s.ca = 8'($urandom_range(15));
      s.ha = 8'($urandom_range(15)); s.hw = rnd(30);
      s.hd = {$urandom, $urandom};
      cyc(s);
    end
    // reset mid-lock, one cycle after a host read grant
    s = '{default: 0}; s.rst = 1; cyc(s);
    s.hr = 1; s.hl = 1; s.ha = 8'h10; cyc(s);
    s.ha = 8'h3; cyc(s);
    s.rst = 0; s.cr = 1; cyc(s);
    s.rst = 1; s.hr = 0; s.hl = 0; s.ca = 8'h3; cyc(s);
    s.cr = 0; cyc(s);
    // randomised phases
    for (int p = 0; p < 16; p++) begin
      pc = $urandom_range(100); ph = $urandom_range(100);
      pl = $urandom_range(60); pw = $urandom_range(80);
      ar = (p % 2) ? 7 : 255;
      for (int i = 0; i < 200; i++) begin
        s.rst = !rnd(1) || (i < 2);
        s.cr = rnd(pc); s.hr = rnd(ph); s.hl = rnd(pl);
        s.cw = rnd(pw); s.hw = rnd(pw);
        s.ca = 8'($urandom_range(ar)); s.ha = 8'($urandom_range(ar));
        s.cd = {$urandom, $urandom}; s.hd = {$urandom, $urandom};
        cyc(s);
      end
    end
    s = '{default: 0}; s.rst = 1;
    repeat (3) cyc(s);
    @(negedge clk);
    #1;
    chk("host_q_drained", 64'(host_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
